pin_lock_ctrl: RTL and testbench
================================

PIN_LOCK_CTRL -- requirements
Module: pin_lock_ctrl

Interface
REQ-001 Parameters SHALL be: DEFAULT_PIN, 16'h1234, PIN loaded into storage at reset (four BCD digits, digit0 in [15:12]).
REQ-002 Parameter: UNLOCK_CYCLES, 2500, clk_500Hz cycles the lock stays open (5 s).
REQ-003 Parameter: LOCKOUT_CYCLES, 15000, clk_500Hz cycles of lockout (30 s).
REQ-004 Parameter: MAX_FAILS, 3, consecutive wrong entries that trigger lockout; legal range 1..3.
REQ-005 Ports SHALL be: clk_500Hz  in  1  sole clock; one clock, all state on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 userPin  in  16  entered PIN from the keypad decoder; valid only while validPin=1.
REQ-008 validPin  in  1  single-cycle strobe marking a completed 4-digit entry.
REQ-009 prog_req  in  1  level switch; requests PIN change while unlocked.
REQ-010 unlocked  out  1  high while state is UNLOCKED or PROG_CONFIRM.
REQ-011 alarm  out  1  high while state is LOCKOUT.
REQ-012 prog_mode  out  1  high while state is PROG_CONFIRM.
REQ-013 prog_ok  out  1  one-cycle pulse when a new PIN is committed.
REQ-014 prog_err  out  1  one-cycle pulse when PIN confirmation mismatches.
REQ-015 fail_cnt  out  2  consecutive wrong entries since last success or lockout end.

Function
REQ-016 All outputs SHALL be registered; response to a validPin strobe SHALL appear on the outputs exactly one cycle after the strobe is sampled.
REQ-017 FSM states SHALL be LOCKED, UNLOCKED, PROG_CONFIRM, LOCKOUT.
REQ-018 LOCKED: validPin with userPin==stored_pin -> UNLOCKED, fail_cnt<=0, open timer loaded with UNLOCK_CYCLES.
REQ-019 LOCKED: validPin with mismatch -> fail_cnt+1; if new count == MAX_FAILS -> LOCKOUT, lockout timer loaded with LOCKOUT_CYCLES; else stay LOCKED.
REQ-020 UNLOCKED: validPin with prog_req=1 -> capture userPin into pending_pin, go PROG_CONFIRM, timer reloaded with UNLOCK_CYCLES.
REQ-021 UNLOCKED: validPin with prog_req=0 -> LOCKED immediately (manual relock).
REQ-022 UNLOCKED or PROG_CONFIRM: timer reaching zero -> LOCKED; timer expiry SHALL win over a validPin in the same cycle, and the strobe is discarded.
REQ-023 PROG_CONFIRM: validPin with userPin==pending_pin -> stored_pin<=pending_pin, prog_ok pulse, go UNLOCKED with timer reloaded.
REQ-024 PROG_CONFIRM: validPin mismatch -> stored_pin unchanged, prog_err pulse, go UNLOCKED with timer reloaded.
REQ-025 LOCKOUT: validPin SHALL be ignored (fail_cnt unchanged); at timer zero -> LOCKED, fail_cnt<=0.
REQ-026 Timer SHALL be a single down-counter wide enough for max(UNLOCK_CYCLES, LOCKOUT_CYCLES); it SHALL not underflow and SHALL hold at zero in LOCKED.
REQ-027 prog_req changing mid-PROG_CONFIRM SHALL have no effect; only the confirm entry matters.

Reset
REQ-028 On rst_n=0: state=LOCKED, stored_pin=DEFAULT_PIN, pending_pin=0, timer=0, fail_cnt=0, unlocked=alarm=prog_mode=prog_ok=prog_err=0.
REQ-029 Reset mid-operation (any state, including mid-lockout or mid-programming) SHALL discard progress and revert stored_pin to DEFAULT_PIN.

Configuration
REQ-030 Macro PIN_LOCK_LOCKOUT_EN SHALL compile in the LOCKOUT state and lockout timing.
REQ-031 With it defined: behaviour per REQ-019/REQ-025.
REQ-032 Without it: no LOCKOUT state, alarm tied 0, fail_cnt saturates at 3 and clears only on success, LOCKOUT_CYCLES unused.

Structure
REQ-033 Package pin_lock_pkg SHALL hold the state enum, the 16-bit PIN typedef, and the BLANK_DIGIT constant (4'hF).
REQ-034 One sub-module, pin_lock_timer (load/count-down/expire flag), SHALL implement the timer; the FSM and storage stay in pin_lock_ctrl.

Verification
REQ-035 Reset, strobe userPin=16'h1234 -> unlocked=1 next cycle; unlocked=0 after 2500 cycles.
REQ-036 Three strobes of 16'h0000 -> fail_cnt 1,2; alarm=1 after the third; 16'h1234 during lockout ignored; alarm=0 and fail_cnt=0 after 15000 cycles.
REQ-037 Unlock, prog_req=1, strobe 16'h5678 twice -> prog_ok pulse; relock; 16'h1234 fails, 16'h5678 unlocks.
REQ-038 Unlock, prog_req=1, strobe 16'h5678 then 16'h9999 -> prog_err pulse, stored PIN still 16'h1234.
REQ-039 Strobe validPin on the exact timer-expiry cycle in UNLOCKED -> LOCKED, strobe ignored; assert rst_n=0 mid-lockout -> all outputs 0, DEFAULT_PIN unlocks.

Source files
------------

// File: rtl/pin_lock_pkg.sv
// Shared types for the PIN lock controller: FSM states, PIN type, keypad blank digit.
package pin_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED       = 2'd0,
        UNLOCKED     = 2'd1,
        PROG_CONFIRM = 2'd2,
        LOCKOUT      = 2'd3
    } state_t;

    typedef logic [15:0] pin_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/pin_lock_timer.sv
// Loadable down-counter for the open / lockout windows; flags the cycle whose edge reaches zero.
module pin_lock_timer #(
    parameter int W = 14
) (
    input  logic         clk_500Hz,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Loading N gives exactly N cycles before the owner leaves its state.
    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/pin_lock_ctrl.sv
// PIN lock controller: unlock, PIN reprogramming with confirmation, optional lockout
// after repeated wrong entries (compiled in by defining PIN_LOCK_LOCKOUT_EN).
//
//   state        | meaning
//   LOCKED       | idle, waiting for a PIN entry
//   UNLOCKED     | open, timer running; entry with prog_req starts a PIN change
//   PROG_CONFIRM | new PIN captured, waiting for the confirming entry
//   LOCKOUT      | too many wrong entries, all entries ignored until timer ends
module pin_lock_ctrl
    import pin_lock_pkg::*;
#(
    parameter pin_t        DEFAULT_PIN    = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 2500,
    parameter int unsigned LOCKOUT_CYCLES = 15000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic        clk_500Hz,
    input  logic        rst_n,
    input  logic [15:0] userPin,
    input  logic        validPin,
    input  logic        prog_req,
    output logic        unlocked,
    output logic        alarm,
    output logic        prog_mode,
    output logic        prog_ok,
    output logic        prog_err,
    output logic [1:0]  fail_cnt
);

    localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] UNLOCK_LD = TMR_W'(UNLOCK_CYCLES);

    if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_max_fails
        $error("pin_lock_ctrl: MAX_FAILS must be 1..3");
    end

    state_t     state_q;
    pin_t       stored_pin_q;
    pin_t       pending_pin_q;
    logic [1:0] fail_cnt_q;
    logic       unlocked_q;
    logic       prog_mode_q;
    logic       prog_ok_q;
    logic       prog_err_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             pin_match;

    assign pin_match = (userPin == stored_pin_q);

`ifdef PIN_LOCK_LOCKOUT_EN
    localparam logic [TMR_W-1:0] LOCKOUT_LD = TMR_W'(LOCKOUT_CYCLES);
    logic       alarm_q;
    logic [2:0] fail_inc;
    logic       hit_max;
    assign fail_inc = {1'b0, fail_cnt_q} + 3'd1;
    assign hit_max  = (fail_inc == 3'(MAX_FAILS));
`endif

    // Timer control mirrors the FSM decisions below; expiry suppresses any same-cycle strobe.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            LOCKED: begin
                if (validPin) begin
                    if (pin_match) begin
                        tmr_load = 1'b1;
                        tmr_val  = UNLOCK_LD;
                    end
`ifdef PIN_LOCK_LOCKOUT_EN
                    else if (hit_max) begin
                        tmr_load = 1'b1;
                        tmr_val  = LOCKOUT_LD;
                    end
`endif
                end
            end
            UNLOCKED: begin
                if (validPin && !tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = prog_req ? UNLOCK_LD : '0;
                end
            end
            PROG_CONFIRM: begin
                if (validPin && !tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_LD;
                end
            end
            default: ;
        endcase
    end

    pin_lock_timer #(.W(TMR_W)) u_timer (
        .clk_500Hz  (clk_500Hz),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOCKED;
            stored_pin_q  <= DEFAULT_PIN;
            pending_pin_q <= '0;
            fail_cnt_q    <= 2'd0;
            unlocked_q    <= 1'b0;
            prog_mode_q   <= 1'b0;
            prog_ok_q     <= 1'b0;
            prog_err_q    <= 1'b0;
`ifdef PIN_LOCK_LOCKOUT_EN
            alarm_q       <= 1'b0;
`endif
        end else begin
            prog_ok_q  <= 1'b0;
            prog_err_q <= 1'b0;
            case (state_q)
                LOCKED: begin
                    if (validPin) begin
                        if (pin_match) begin
                            state_q    <= UNLOCKED;
                            fail_cnt_q <= 2'd0;
                            unlocked_q <= 1'b1;
                        end
`ifdef PIN_LOCK_LOCKOUT_EN
                        else if (hit_max) begin
                            state_q    <= LOCKOUT;
                            fail_cnt_q <= fail_inc[1:0];
                            alarm_q    <= 1'b1;
                        end else begin
                            fail_cnt_q <= fail_inc[1:0];
                        end
`else
                        else if (fail_cnt_q != 2'd3) begin
                            fail_cnt_q <= fail_cnt_q + 2'd1;
                        end
`endif
                    end
                end
                UNLOCKED: begin
                    if (tmr_expire) begin
                        state_q    <= LOCKED;
                        unlocked_q <= 1'b0;
                    end else if (validPin) begin
                        if (prog_req) begin
                            pending_pin_q <= userPin;
                            state_q       <= PROG_CONFIRM;
                            prog_mode_q   <= 1'b1;
                        end else begin
                            state_q    <= LOCKED;
                            unlocked_q <= 1'b0;
                        end
                    end
                end
                PROG_CONFIRM: begin
                    if (tmr_expire) begin
                        state_q     <= LOCKED;
                        unlocked_q  <= 1'b0;
                        prog_mode_q <= 1'b0;
                    end else if (validPin) begin
                        state_q     <= UNLOCKED;
                        prog_mode_q <= 1'b0;
                        if (userPin == pending_pin_q) begin
                            stored_pin_q <= pending_pin_q;
                            prog_ok_q    <= 1'b1;
                        end else begin
                            prog_err_q <= 1'b1;
                        end
                    end
                end
`ifdef PIN_LOCK_LOCKOUT_EN
                LOCKOUT: begin
                    if (tmr_expire) begin
                        state_q    <= LOCKED;
                        fail_cnt_q <= 2'd0;
                        alarm_q    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q     <= LOCKED;
                    unlocked_q  <= 1'b0;
                    prog_mode_q <= 1'b0;
                end
            endcase
        end
    end

    assign unlocked  = unlocked_q;
    assign prog_mode = prog_mode_q;
    assign prog_ok   = prog_ok_q;
    assign prog_err  = prog_err_q;
    assign fail_cnt  = fail_cnt_q;
`ifdef PIN_LOCK_LOCKOUT_EN
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Directed bench for pin_lock_ctrl; expectations follow PIN_LOCK_LOCKOUT_EN when it is defined.
module tb_pin_lock_ctrl;

    logic        clk_500Hz;
    logic        rst_n;
    logic [15:0] userPin;
    logic        validPin;
    logic        prog_req;
    logic        unlocked;
    logic        alarm;
    logic        prog_mode;
    logic        prog_ok;
    logic        prog_err;
    logic [1:0]  fail_cnt;

    int total = 0;
    int bad   = 0;

    pin_lock_ctrl dut (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .userPin   (userPin),
        .validPin  (validPin),
        .prog_req  (prog_req),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .prog_mode (prog_mode),
        .prog_ok   (prog_ok),
        .prog_err  (prog_err),
        .fail_cnt  (fail_cnt)
    );

    initial clk_500Hz = 1'b0;
    always #5 clk_500Hz = ~clk_500Hz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, when the response is visible.
    task automatic strobe(input logic [15:0] pin);
        userPin  = pin;
        validPin = 1'b1;
        @(negedge clk_500Hz);
        validPin = 1'b0;
        userPin  = 16'h0000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_500Hz);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".unlocked"},  unlocked,  0);
        chk({tag, ".alarm"},     alarm,     0);
        chk({tag, ".prog_mode"}, prog_mode, 0);
        chk({tag, ".prog_ok"},   prog_ok,   0);
        chk({tag, ".prog_err"},  prog_err,  0);
        chk({tag, ".fail_cnt"},  fail_cnt,  0);
    endtask

    initial begin
        rst_n    = 1'b0;
        validPin = 1'b0;
        userPin  = 16'h0000;
        prog_req = 1'b0;
        cycles(2);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Unlock and open window length
        strobe(16'h1234);
        chk("unlock", unlocked, 1);
        chk("unlock.fail", fail_cnt, 0);
        cycles(2499);
        chk("open.last_cycle", unlocked, 1);
        cycles(1);
        chk("open.expired", unlocked, 0);

        // Wrong entries
        strobe(16'h0000);
        chk("wrong1.fail", fail_cnt, 1);
        strobe(16'h0000);
        chk("wrong2.fail", fail_cnt, 2);
        chk("wrong2.alarm", alarm, 0);
        strobe(16'h0000);
        chk("wrong3.fail", fail_cnt, 3);
`ifdef PIN_LOCK_LOCKOUT_EN
        chk("wrong3.alarm", alarm, 1);
        strobe(16'h1234);
        chk("lockout.ignore.unlocked", unlocked, 0);
        chk("lockout.ignore.fail", fail_cnt, 3);
        cycles(14998);
        chk("lockout.last_cycle", alarm, 1);
        cycles(1);
        chk("lockout.end.alarm", alarm, 0);
        chk("lockout.end.fail", fail_cnt, 0);
`else
        chk("wrong3.alarm", alarm, 0);
        strobe(16'h0000);
        chk("wrong4.saturate", fail_cnt, 3);
        strobe(16'h1234);
        chk("sat.unlock", unlocked, 1);
        chk("sat.clear", fail_cnt, 0);
        strobe(16'h1111);
        chk("sat.relock", unlocked, 0);
`endif

        // Successful PIN change; prog_req dropped during confirm has no effect
        strobe(16'h1234);
        chk("prog.unlock", unlocked, 1);
        prog_req = 1'b1;
        strobe(16'h5678);
        chk("prog.mode", prog_mode, 1);
        chk("prog.mode.unlocked", unlocked, 1);
        prog_req = 1'b0;
        strobe(16'h5678);
        chk("prog.ok", prog_ok, 1);
        chk("prog.ok.err", prog_err, 0);
        chk("prog.ok.mode", prog_mode, 0);
        chk("prog.ok.unlocked", unlocked, 1);
        cycles(1);
        chk("prog.ok.pulse", prog_ok, 0);
        strobe(16'h0000);
        chk("manual.relock", unlocked, 0);
        strobe(16'h1234);
        chk("newpin.old_fails", unlocked, 0);
        chk("newpin.old_fails.cnt", fail_cnt, 1);
        strobe(16'h5678);
        chk("newpin.unlock", unlocked, 1);
        chk("newpin.unlock.cnt", fail_cnt, 0);

        // Reset reverts the PIN
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset.unlocked");
        cycles(1);
        rst_n = 1'b1;
        strobe(16'h5678);
        chk("revert.old_fails", unlocked, 0);
        strobe(16'h1234);
        chk("revert.unlock", unlocked, 1);

        // Confirmation mismatch
        prog_req = 1'b1;
        strobe(16'h5678);
        chk("err.mode", prog_mode, 1);
        strobe(16'h9999);
        chk("err.pulse", prog_err, 1);
        chk("err.ok", prog_ok, 0);
        chk("err.unlocked", unlocked, 1);
        chk("err.mode_off", prog_mode, 0);
        prog_req = 1'b0;
        strobe(16'h0000);
        chk("err.relock", unlocked, 0);
        strobe(16'h5678);
        chk("err.keep.reject", unlocked, 0);
        strobe(16'h1234);
        chk("err.keep.unlock", unlocked, 1);

        // Strobe on the expiry cycle is discarded
        prog_req = 1'b1;
        cycles(2499);
        chk("race.before", unlocked, 1);
        strobe(16'h5678);
        chk("race.unlocked", unlocked, 0);
        chk("race.prog_mode", prog_mode, 0);
        prog_req = 1'b0;
        strobe(16'h5678);
        chk("race.pin_kept", fail_cnt, 1);

`ifdef PIN_LOCK_LOCKOUT_EN
        strobe(16'h0000);
        chk("relock.fail2", fail_cnt, 2);
        strobe(16'h0000);
        chk("relock.alarm", alarm, 1);
        cycles(100);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset.lockout");
        cycles(1);
        rst_n = 1'b1;
`else
        strobe(16'h1234);
        chk("midprog.unlock", unlocked, 1);
        prog_req = 1'b1;
        strobe(16'h5678);
        chk("midprog.mode", prog_mode, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset.prog");
        prog_req = 1'b0;
        cycles(1);
        rst_n = 1'b1;
`endif
        strobe(16'h1234);
        chk("after_reset.unlock", unlocked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
